// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown round controller: FSM encoding,
// datapath widths and the saturating score accumulator.
package countdown_pkg;

    // Width of the round start value and the remaining count
    localparam int CNT_W   = 7;
    // Width of the accumulated score
    localparam int SCORE_W = 8;
    // Width of the completed-round counter
    localparam int ROUND_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_EXPIRED = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Adds the remaining count to the score, clamping at the 8-bit maximum
    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] score_v,
        input logic [CNT_W-1:0]   count_v
    );
        logic [SCORE_W:0] sum_v;
        sum_v = {1'b0, score_v} + {{(SCORE_W + 1 - CNT_W){1'b0}}, count_v};
        if (sum_v[SCORE_W]) begin
            return {SCORE_W{1'b1}};
        end else begin
            return sum_v[SCORE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing one tick every CLOCK enabled cycles. The count
// freezes while en is low so a paused round neither loses nor gains time;
// clr restarts the interval when a round is (re)loaded.
module tick_gen #(
    parameter int CLOCK = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (CLOCK > 1) ? $clog2(CLOCK) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLOCK - 1);

    logic [PW-1:0] presc_r;

    // Tick is asserted during the enabled cycle in which the count sits at its last value
    assign tick = en && (presc_r == LAST);

    // Prescaler count: clear wins over enable, wraps after the last value, holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
        end else if (clr) begin
            presc_r <= {PW{1'b0}};
        end else if (en) begin
            if (presc_r == LAST) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end else begin
            presc_r <= presc_r;
        end
    end

endmodule

// File: rtl/countdown_round_ctrl.sv
// Reaction-game round controller: counts each round down from a start
// value, scores the remaining count when the player hits, and ends the game
// after a fixed number of successful rounds or when a round times out.
module countdown_round_ctrl
    import countdown_pkg::*;
#(
    parameter int CLOCK  = 50000000,
    parameter int ROUNDS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   from,
    input  logic               start,
    input  logic               pause,
    input  logic               hit,
    output logic [CNT_W-1:0]   current,
    output logic               running,
    output logic               expired,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic [ROUND_W-1:0] round
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   current_r;
    logic [CNT_W-1:0]   current_s;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] score_s;
    logic [ROUND_W-1:0] round_r;
    logic [ROUND_W-1:0] round_s;
    logic               running_r;
    logic               expired_r;
    logic               done_r;

    logic               start_ok_s;
    logic               presc_en_s;
    logic               presc_clr_s;
    logic               tick_s;

    // A game may only begin from a quiescent state with a non-zero start value
    assign start_ok_s  = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && (from != {CNT_W{1'b0}});
    // Hit and pause pre-empt a tick in RUN, so the prescaler must not advance in those cycles
    assign presc_en_s  = (state_r == ST_RUN) && !hit && !pause;
    assign presc_clr_s = start_ok_s || ((state_r == ST_RUN) && hit);

    tick_gen #(
        .CLOCK (CLOCK)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en_s),
        .clr   (presc_clr_s),
        .tick  (tick_s)
    );

    // Next-state and datapath decode; priority inside RUN is hit, then pause, then tick
    always_comb begin
        state_s   = state_r;
        current_s = current_r;
        score_s   = score_r;
        round_s   = round_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_s   = ST_RUN;
                    current_s = from;
                    score_s   = {SCORE_W{1'b0}};
                    round_s   = {ROUND_W{1'b0}};
                end else begin
                    state_s   = state_r;
                end
            end
            ST_RUN: begin
                if (hit) begin
                    score_s   = sat_add_score(score_r, current_r);
                    round_s   = round_r + ROUND_W'(1);
                    current_s = from;
                    if ((round_r + ROUND_W'(1)) == LAST_ROUND) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else if (pause) begin
                    state_s = ST_PAUSED;
                end else if (tick_s) begin
                    if (current_r > CNT_W'(1)) begin
                        current_s = current_r - CNT_W'(1);
                    end else begin
                        current_s = {CNT_W{1'b0}};
                        state_s   = ST_EXPIRED;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (pause) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_EXPIRED: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                current_s = {CNT_W{1'b0}};
                score_s   = {SCORE_W{1'b0}};
                round_s   = {ROUND_W{1'b0}};
            end
        endcase
    end

    // State and output registers; status flags are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            current_r <= {CNT_W{1'b0}};
            score_r   <= {SCORE_W{1'b0}};
            round_r   <= {ROUND_W{1'b0}};
            running_r <= 1'b0;
            expired_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            current_r <= current_s;
            score_r   <= score_s;
            round_r   <= round_s;
            running_r <= (state_s == ST_RUN);
            expired_r <= (state_s == ST_EXPIRED);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign current = current_r;
    assign running = running_r;
    assign expired = expired_r;
    assign done    = done_r;
    assign score   = score_r;
    assign round   = round_r;

endmodule

// File: tb/tb_countdown_round_ctrl.sv
// Directed bench for countdown_round_ctrl with CLOCK=4. The main instance
// runs ROUNDS=2; a second instance with ROUNDS=4 exercises score saturation.
module tb_countdown_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] from = 7'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       hit = 1'b0;
    logic [6:0] current;
    logic       running, expired, done;
    logic [7:0] score;
    logic [3:0] round;

    logic [6:0] from2 = 7'd0;
    logic       start2 = 1'b0;
    logic       pause2 = 1'b0;
    logic       hit2 = 1'b0;
    logic [6:0] current2;
    logic       running2, expired2, done2;
    logic [7:0] score2;
    logic [3:0] round2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    countdown_round_ctrl #(.CLOCK(4), .ROUNDS(2)) dut (
        .clk(clk), .reset(reset), .from(from), .start(start), .pause(pause), .hit(hit),
        .current(current), .running(running), .expired(expired), .done(done),
        .score(score), .round(round)
    );

    countdown_round_ctrl #(.CLOCK(4), .ROUNDS(4)) dut2 (
        .clk(clk), .reset(reset), .from(from2), .start(start2), .pause(pause2), .hit(hit2),
        .current(current2), .running(running2), .expired(expired2), .done(done2),
        .score(score2), .round(round2)
    );

    wire [21:0] obs  = {current, running, expired, done, score, round};
    wire [21:0] obs2 = {current2, running2, expired2, done2, score2, round2};

    typedef struct {
        logic        rst;
        logic        st;
        logic        pz;
        logic        ht;
        logic [6:0]  fr;
        int          wt;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [21:0] ex(input int cur, input logic run, input logic exr,
                                       input logic dn, input int sc, input int rd);
        logic [6:0] c;
        logic [7:0] s;
        logic [3:0] r;
        c = cur[6:0];
        s = sc[7:0];
        r = rd[3:0];
        return {c, run, exr, dn, s, r};
    endfunction

    function automatic vec_t mk(input logic rs, input logic st, input logic pz, input logic ht,
                                input int fr, input int wt, input logic [21:0] e);
        vec_t v;
        v.rst = rs; v.st = st; v.pz = pz; v.ht = ht;
        v.fr = fr[6:0]; v.wt = wt; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got cur=%0d run=%0d exp=%0d done=%0d score=%0d round=%0d, want cur=%0d run=%0d exp=%0d done=%0d score=%0d round=%0d",
                     name, got[21:15], got[14], got[13], got[12], got[11:4], got[3:0],
                     want[21:15], want[14], want[13], want[12], want[11:4], want[3:0]);
        end
    endtask

    // Drive one vector's pulses for a single cycle, then idle until wt edges have passed
    task automatic apply(input vec_t v);
        reset = v.rst; start = v.st; pause = v.pz; hit = v.ht; from = v.fr;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; pause = 1'b0; hit = 1'b0;
        repeat (v.wt - 1) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst   st    pz    ht    from wt  expected {cur,run,exp,done,score,round}
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1,  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1,  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1,  ex(0, 0, 0, 0, 0, 0)));  // from=0 ignored
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 5, 1,  ex(5, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5, 3,  ex(5, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5, 1,  ex(4, 1, 0, 0, 0, 0)));  // first tick
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 5, 1,  ex(5, 1, 0, 0, 4, 1)));  // hit at 4
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5, 12, ex(2, 1, 0, 0, 4, 1)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 5, 1,  ex(5, 0, 0, 1, 6, 2)));  // hit at 2 -> DONE
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5, 5,  ex(5, 0, 0, 1, 6, 2)));  // DONE holds
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 1,  ex(1, 1, 0, 0, 0, 0)));  // restart from DONE
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1, 3,  ex(1, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1, 1,  ex(1, 1, 0, 0, 1, 1)));  // hit beats tick at 1
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1, 1,  ex(1, 1, 0, 0, 1, 1)));  // no expiry
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1, 1,  ex(1, 0, 0, 0, 1, 1)));  // pause
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1, 8,  ex(1, 0, 0, 0, 1, 1)));  // hit ignored paused
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1, 1,  ex(1, 1, 0, 0, 1, 1)));  // resume
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1, 1,  ex(1, 1, 0, 0, 1, 1)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1, 2,  ex(0, 0, 1, 0, 1, 1)));  // expire
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1, 1,  ex(0, 0, 0, 0, 1, 1)));  // IDLE, held
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3, 1,  ex(3, 1, 0, 0, 0, 0)));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6, 1,  ex(3, 1, 0, 0, 0, 0)));  // start in RUN ignored
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6, 1,  ex(3, 0, 0, 0, 0, 0)));  // pause
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6, 1,  ex(3, 0, 0, 0, 0, 0)));  // start in PAUSED ignored
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 6, 1,  ex(0, 0, 0, 0, 0, 0)));  // reset mid-pause
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1,  ex(0, 0, 0, 0, 0, 0)));  // from=0 stays IDLE
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4, 1,  ex(0, 0, 0, 0, 0, 0)));  // pause/hit in IDLE

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Full countdown from 3 to timeout
        pulse_reset();
        from = 7'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cd_start", obs, ex(3, 1, 0, 0, 0, 0));
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("cd_cyc%0d", k), obs, ex(3 - k / 4, 1, 0, 0, 0, 0));
        end
        @(negedge clk);
        check("cd_expired", obs, ex(0, 0, 1, 0, 0, 0));
        @(negedge clk);
        check("cd_idle", obs, ex(0, 0, 0, 0, 0, 0));

        // Pause two cycles after a tick; the remaining two cycles of the interval survive the pause
        pulse_reset();
        from = 7'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pz_tick", obs, ex(6, 1, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("pz_hold%0d", k), obs, ex(6, 0, 0, 0, 0, 0));
            @(negedge clk);
        end
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("pz_resume", obs, ex(6, 1, 0, 0, 0, 0));
        @(negedge clk);
        check("pz_r1", obs, ex(6, 1, 0, 0, 0, 0));
        @(negedge clk);
        check("pz_r2_tick", obs, ex(5, 1, 0, 0, 0, 0));

        // Score saturation on the four-round instance; from is reloaded on every hit
        pulse_reset();
        from2 = 7'd127; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("sat_start", obs2, ex(127, 1, 0, 0, 0, 0));
        from2 = 7'd123; hit2 = 1'b1;
        @(negedge clk);
        check("sat_hit1", obs2, ex(123, 1, 0, 0, 127, 1));
        from2 = 7'd100;
        @(negedge clk);
        check("sat_hit2", obs2, ex(100, 1, 0, 0, 250, 2));
        @(negedge clk);
        check("sat_hit3", obs2, ex(100, 1, 0, 0, 255, 3));
        @(negedge clk);
        hit2 = 1'b0;
        check("sat_hit4_done", obs2, ex(100, 0, 0, 1, 255, 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_round_ctrl.md
COUNTDOWN_ROUND_CTRL -- requirements
Module: countdown_round_ctrl

Interface
REQ-001 Parameter CLOCK, default 50000000, clk cycles per countdown tick (1 s at 50 MHz).
REQ-002 Parameter ROUNDS, default 8, number of rounds per game (1..15).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 system clock, then reset input 1 synchronous active-high reset.
REQ-004 Port from, input, 7, round start value; sampled on every load.
REQ-005 Port start, input, 1, single-cycle pulse; begins a game.
REQ-006 Port pause, input, 1, single-cycle pulse; toggles RUN/PAUSED.
REQ-007 Port hit, input, 1, single-cycle pulse; player stops the current round.
REQ-008 Port current, output, 7, remaining count of the active round.
REQ-009 Port running, output, 1, high in RUN only.
REQ-010 Port expired, output, 1, one-cycle pulse when a round times out.
REQ-011 Port done, output, 1, high in DONE.
REQ-012 Port score, output, 8, accumulated score.
REQ-013 Port round, output, 4, rounds completed by hit.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSED, EXPIRED, DONE.
REQ-015 IDLE or DONE + start with from!=0 -> RUN: current=from, score=0, round=0, prescaler=0.
REQ-016 start with from==0 SHALL be ignored; start in RUN/PAUSED/EXPIRED SHALL be ignored.
REQ-017 Prescaler SHALL count 0..CLOCK-1 in RUN only; tick asserts in the cycle it equals CLOCK-1, then it wraps to 0.
REQ-018 Prescaler SHALL hold its value in PAUSED; no ticks are lost or added across a pause.
REQ-019 RUN + tick with current>1 -> current decrements by 1 on the next edge.
REQ-020 RUN + tick with current==1 -> current=0, state EXPIRED.
REQ-021 EXPIRED SHALL last exactly one cycle with expired=1, then go to IDLE; score and round are held.
REQ-022 RUN + hit -> score=min(score+current,255) (saturating 8-bit), round+1, current=from, prescaler=0.
REQ-023 If that hit makes round==ROUNDS, the next state SHALL be DONE; otherwise RUN.
REQ-024 RUN + pause -> PAUSED; PAUSED + pause -> RUN; hit and tick SHALL have no effect in PAUSED.
REQ-025 Same-cycle priority in RUN SHALL be hit > pause > tick: hit plus tick on current==1 scores 1, with no expiry.
REQ-026 DONE SHALL hold score and round until start or reset.
REQ-027 All outputs SHALL be registered; current reflects a tick one cycle after the tick cycle.

Reset
REQ-028 reset SHALL take priority over all inputs in any state, including mid-round and mid-pause.
REQ-029 On reset: state IDLE, current 0, score 0, round 0, prescaler 0, running 0, expired 0, done 0.

Structure
REQ-030 State encoding and score/round widths SHALL be defined in shared package countdown_pkg.
REQ-031 The prescaler SHALL be sub-module tick_gen (params CLOCK; inputs clk, reset, en, clr; output tick), width $clog2(CLOCK).
REQ-032 Expected RTL size is 150-250 lines.

Verification (CLOCK=4, ROUNDS=2)
REQ-033 from=3, start -> running=1, current 3,2,1 at 4-cycle spacing, then expired pulses 1 cycle, then IDLE with score=0.
REQ-034 from=5, start, hit when current=4 -> score=4, round=1, current=5; second hit at current=2 -> score=6, round=2, done=1.
REQ-035 RUN, pause 2 cycles after a tick, hold 10 cycles, pause again -> next tick 2 cycles after resume, current unchanged while paused.
REQ-036 current=1, hit and tick in the same cycle -> score+=1, no expired pulse, current reloads.
REQ-037 score=250 (force via rounds at from=127), hit at current=100 -> score=255.
REQ-038 reset asserted in PAUSED with current=3 -> next cycle all outputs 0, state IDLE; start with from=0 -> stays IDLE.
